// File: rtl/maxnet_frame_loader.sv
// Maxnet frame loader: assembles a 4-word frame from a valid/ready stream,
// presents it on x0..x3, pulses core_start, then holds the frame until the
// core reports done. Malformed frames and core timeouts are flagged.
module maxnet_frame_loader #(
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic [DATA_W-1:0] x0,
    output logic [DATA_W-1:0] x1,
    output logic [DATA_W-1:0] x2,
    output logic [DATA_W-1:0] x3,
    output logic              core_start,
    input  logic              core_done,
    output logic              busy,
    output logic              frame_err,
    output logic              timeout_err,
    output logic [7:0]        frame_cnt
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        SKIP  = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } state_t;

    // Last wait_cnt value still allowed before the core is declared stuck.
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT - 1);

    state_t      state_reg;
    logic [1:0]  idx_reg;
    logic [7:0]  wait_cnt_reg;
    logic [7:0]  frame_cnt_reg;
    logic        core_start_reg;
    logic        busy_reg;
    logic        frame_err_reg;
    logic        timeout_err_reg;

    logic        accept;
    logic        word_wr;

    // Stream is open only while collecting or discarding words, and never in reset.
    assign in_ready = rst & ((state_reg == FILL) | (state_reg == SKIP));
    assign accept   = in_valid & in_ready;

    // A word lands in x[idx] unless it is an early in_last, which is dropped.
    assign word_wr  = accept & (state_reg == FILL) & ((idx_reg == 2'd3) | ~in_last);

    // One holding register per frame word; each loads only when idx points at it.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_word
            logic [DATA_W-1:0] word_reg;

            // Capture the accepted word into this slot.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    word_reg <= '0;
                end else if (word_wr && (idx_reg == 2'(gi))) begin
                    word_reg <= in_data;
                end
            end
        end
    endgenerate

    assign x0 = g_word[0].word_reg;
    assign x1 = g_word[1].word_reg;
    assign x2 = g_word[2].word_reg;
    assign x3 = g_word[3].word_reg;

    // Frame sequencing, core handshake, counters and registered status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= FILL;
            idx_reg         <= 2'd0;
            wait_cnt_reg    <= 8'd0;
            frame_cnt_reg   <= 8'd0;
            core_start_reg  <= 1'b0;
            busy_reg        <= 1'b0;
            frame_err_reg   <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            core_start_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            case (state_reg)
                FILL: begin
                    if (accept) begin
                        if (idx_reg == 2'd3) begin
                            idx_reg <= 2'd0;
                            if (in_last) begin
                                state_reg      <= START;
                                core_start_reg <= 1'b1;
                                busy_reg       <= 1'b1;
                            end else begin
                                // Fourth word without in_last: drop the rest of this frame.
                                frame_err_reg <= 1'b1;
                                state_reg     <= SKIP;
                            end
                        end else if (in_last) begin
                            // Frame ended early: restart collection from word 0.
                            frame_err_reg <= 1'b1;
                            idx_reg       <= 2'd0;
                        end else begin
                            idx_reg <= idx_reg + 2'd1;
                        end
                    end
                end
                SKIP: begin
                    if (accept && in_last) begin
                        state_reg <= FILL;
                    end
                end
                START: begin
                    wait_cnt_reg <= 8'd0;
                    state_reg    <= WAIT;
                end
                WAIT: begin
                    wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    // done takes priority over the timeout limit in the same cycle
                    if (core_done) begin
                        frame_cnt_reg <= frame_cnt_reg + 8'd1;
                        busy_reg      <= 1'b0;
                        state_reg     <= FILL;
                    end else if (wait_cnt_reg == WAIT_LIMIT) begin
                        timeout_err_reg <= 1'b1;
                        busy_reg        <= 1'b0;
                        state_reg       <= FILL;
                    end
                end
                default: begin
                    state_reg <= FILL;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign core_start  = core_start_reg;
    assign busy        = busy_reg;
    assign frame_err   = frame_err_reg;
    assign timeout_err = timeout_err_reg;
    assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_maxnet_frame_loader.sv
// Bench for maxnet_frame_loader: directed scenarios plus randomized frames,
// checked against a word-queue reference model of frame assembly.
module tb_maxnet_frame_loader;

    localparam int DW = 8;
    localparam int MW = 8;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic [DW-1:0] x0, x1, x2, x3;
    logic          core_start;
    logic          core_done;
    logic          busy;
    logic          frame_err;
    logic          timeout_err;
    logic [7:0]    frame_cnt;

    maxnet_frame_loader #(.DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .x0         (x0),
        .x1         (x1),
        .x2         (x2),
        .x3         (x3),
        .core_start (core_start),
        .core_done  (core_done),
        .busy       (busy),
        .frame_err  (frame_err),
        .timeout_err(timeout_err),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] xs [4];
    assign xs[0] = x0;
    assign xs[1] = x1;
    assign xs[2] = x2;
    assign xs[3] = x3;

    // reference model state
    logic [DW-1:0] exp_x [4];
    logic [DW-1:0] fq [$];
    logic [7:0]    exp_cnt;
    logic          exp_to;
    bit            skipping;

    int total = 0;
    int bad   = 0;
    int frames = 0;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) exp_x[i] = '0;
        fq.delete();
        exp_cnt  = 8'd0;
        exp_to   = 1'b0;
        skipping = 1'b0;
    endtask

    // Offer one word (after 'gap' idle cycles), wait for acceptance, update the model.
    task automatic send_word(input logic [DW-1:0] d, input logic l, input int gap,
                             output bit complete);
        bit got;
        bit err;
        complete = 1'b0;
        got      = 1'b0;
        err      = 1'b0;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = DW'($urandom);
            in_last  = 1'($urandom);
            @(posedge clk); #1;
        end
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if (in_ready === 1'b1) begin
                got = 1'b1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL accept_wait got=no_accept want=accept data=%0h", d);
        end else begin
            if (skipping) begin
                if (l) skipping = 1'b0;
            end else begin
                fq.push_back(d);
                if (fq.size() < 4) begin
                    if (l) begin
                        err = 1'b1;
                        fq.delete();
                    end else begin
                        exp_x[fq.size()-1] = d;
                    end
                end else begin
                    exp_x[3] = d;
                    fq.delete();
                    if (l) complete = 1'b1;
                    else begin
                        err      = 1'b1;
                        skipping = 1'b1;
                    end
                end
            end
            total++;
            if (frame_err !== err) begin
                bad++;
                $display("FAIL frame_err got=%0b want=%0b data=%0h", frame_err, err, d);
            end
        end
    endtask

    // Act as the core: done in WAIT cycle k (k > MW means never within the limit).
    task automatic run_core(input int k);
        total++;
        if ({core_start, busy, in_ready} !== 3'b110) begin
            bad++;
            $display("FAIL start_flags got=%b want=110", {core_start, busy, in_ready});
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (xs[i] !== exp_x[i]) begin
                bad++;
                $display("FAIL x_start idx=%0d got=%0h want=%0h", i, xs[i], exp_x[i]);
            end
        end
        for (int c = 1; c <= MW; c++) begin
            @(posedge clk); #1;
            total++;
            if ({core_start, busy, in_ready} !== 3'b010) begin
                bad++;
                $display("FAIL wait_flags cyc=%0d got=%b want=010", c, {core_start, busy, in_ready});
            end
            for (int i = 0; i < 4; i++) begin
                total++;
                if (xs[i] !== exp_x[i]) begin
                    bad++;
                    $display("FAIL x_hold idx=%0d got=%0h want=%0h", i, xs[i], exp_x[i]);
                end
            end
            if (c == k) begin
                core_done = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        core_done = 1'b0;
        if (k <= MW) exp_cnt = exp_cnt + 8'd1;
        else exp_to = 1'b1;
        total++;
        if (frame_cnt !== exp_cnt) begin
            bad++;
            $display("FAIL frame_cnt got=%0d want=%0d", frame_cnt, exp_cnt);
        end
        total++;
        if (timeout_err !== exp_to) begin
            bad++;
            $display("FAIL timeout_err got=%0b want=%0b", timeout_err, exp_to);
        end
        total++;
        if ({busy, in_ready, core_start} !== 3'b010) begin
            bad++;
            $display("FAIL after_wait got=%b want=010", {busy, in_ready, core_start});
        end
        if (k > MW) begin
            core_done = 1'b1;
            @(posedge clk); #1;
            core_done = 1'b0;
            total++;
            if (frame_cnt !== exp_cnt) begin
                bad++;
                $display("FAIL done_ignored got=%0d want=%0d", frame_cnt, exp_cnt);
            end
        end
        frames++;
        $display("frame %0d: x=%0h/%0h/%0h/%0h done_cycle=%0d cnt=%0d timeout=%0b",
                 frames, exp_x[0], exp_x[1], exp_x[2], exp_x[3], k, exp_cnt, exp_to);
    endtask

    // Send a clean 4-word frame and serve it with done in WAIT cycle k.
    task automatic clean_frame(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                               input logic [DW-1:0] w2, input logic [DW-1:0] w3,
                               input int k);
        bit c;
        logic [DW-1:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int i = 0; i < 4; i++) begin
            send_word(w[i], i == 3, 0, c);
        end
        total++;
        if (!c || core_start !== 1'b1) begin
            bad++;
            $display("FAIL frame_start got=%0b want=1", core_start);
        end else begin
            run_core(k);
        end
    endtask

    task automatic check_zero(input string tag);
        total++;
        if ({x0, x1, x2, x3, frame_cnt, timeout_err, core_start, busy, frame_err} !== '0) begin
            bad++;
            $display("FAIL %s got=%h_%h_%h_%h cnt=%0d to=%b st=%b busy=%b err=%b want=all_zero",
                     tag, x0, x1, x2, x3, frame_cnt, timeout_err, core_start, busy, frame_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; core_done = 1'b0;
        model_reset();
        #12;
        check_zero("reset_values");
        #10 rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset got=%b want=1", in_ready);
        end
    endtask

    task automatic test_basic_frame();
        clean_frame(8'h10, 8'h20, 8'h30, 8'h40, 6);
    endtask

    task automatic test_early_last();
        bit c;
        send_word(8'hAA, 1'b0, 0, c);
        send_word(8'hBB, 1'b1, 0, c);
        @(posedge clk); #1;
        total++;
        if (frame_err !== 1'b0 || x1 !== exp_x[1]) begin
            bad++;
            $display("FAIL early_last got=err%b x1=%0h want=err0 x1=%0h", frame_err, x1, exp_x[1]);
        end
        clean_frame(8'h01, 8'h02, 8'h03, 8'h04, 2);
    endtask

    task automatic test_missing_last();
        bit c;
        for (int i = 0; i < 4; i++) send_word(8'h50 + 8'(i), 1'b0, 0, c);
        send_word(8'h60, 1'b0, 0, c);
        send_word(8'h61, 1'b1, 0, c);
        clean_frame(8'hC1, 8'hC2, 8'hC3, 8'hC4, 1);
    endtask

    task automatic test_done_at_limit();
        clean_frame(8'h7E, 8'h7F, 8'h80, 8'h81, MW);
    endtask

    task automatic test_timeout();
        clean_frame(8'hD0, 8'hD1, 8'hD2, 8'hD3, MW + 2);
        clean_frame(8'hE0, 8'hE1, 8'hE2, 8'hE3, 3);
    endtask

    task automatic test_random();
        bit c;
        int kind, n;
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 4);
            c = 1'b0;
            if (kind == 1) begin
                n = $urandom_range(1, 3);
                for (int i = 1; i <= n; i++)
                    send_word(DW'($urandom), i == n, $urandom_range(0, 2), c);
            end else if (kind == 2) begin
                for (int i = 0; i < 4; i++)
                    send_word(DW'($urandom), 1'b0, $urandom_range(0, 2), c);
                n = $urandom_range(1, 3);
                for (int i = 1; i <= n; i++)
                    send_word(DW'($urandom), i == n, $urandom_range(0, 2), c);
            end else begin
                for (int i = 0; i < 4; i++)
                    send_word(DW'($urandom), i == 3, $urandom_range(0, 2), c);
            end
            if (c) run_core($urandom_range(1, MW + 2));
        end
    endtask

    task automatic test_reset_mid();
        bit c;
        for (int i = 0; i < 4; i++) send_word(8'h90 + 8'(i), i == 3, 0, c);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b0;
        model_reset();
        #1 check_zero("reset_mid_wait");
        #3 rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_mid_reset got=%b want=1", in_ready);
        end
        clean_frame(8'h31, 8'h32, 8'h33, 8'h34, 4);
        send_word(8'hF1, 1'b0, 0, c);
        send_word(8'hF2, 1'b0, 1, c);
        #2 rst = 1'b0;
        model_reset();
        #1 check_zero("reset_mid_fill");
        #3 rst = 1'b1;
        @(posedge clk); #1;
        clean_frame(8'h0A, 8'h0B, 8'h0C, 8'h0D, 5);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_early_last();
        test_missing_last();
        test_done_at_limit();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
